pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: sequences PC through BOOT/REQ/HOLD, hands fetched words to decode, applies redirects.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VECTOR instead of being word-aligned.
module pc_fetch_ctrl #(
  parameter int              SIZE        = 32,
  parameter logic [SIZE-1:0] RESET_ADDR  = SIZE'(32'h0000_0000),
  parameter logic [SIZE-1:0] TRAP_VECTOR = SIZE'(32'h0000_0010)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [SIZE-1:0] PC,
  output logic [SIZE-1:0] PC_in,
  output logic            imem_req,
  output logic [SIZE-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [SIZE-1:0] imem_rdata,
  output logic [SIZE-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [SIZE-1:0] redirect_target,
  output logic            misalign,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t          state_q, state_d;
  logic            imem_req_q, imem_req_d;
  logic [SIZE-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            pend_q, pend_d;
  logic [SIZE-1:0] pend_tgt_q, pend_tgt_d;
  logic [SIZE-1:0] pc_next;
  logic            mis;

  // Returns {misalign, applied_pc} for a redirect target.
  function automatic logic [SIZE:0] apply_target(input logic [SIZE-1:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) return {1'b1, TRAP_VECTOR};
    return {1'b0, t};
`else
    return {1'b0, t[SIZE-1:2], 2'b00};
`endif
  endfunction

`ifndef PC_MISALIGN_TRAP_EN
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    pc_next       = PC;
    mis           = 1'b0;
    case (state_q)
      BOOT: begin
        pc_next    = RESET_ADDR;
        state_d    = REQ;
        imem_req_d = 1'b1;
        pend_d     = 1'b0;
      end
      REQ: begin
        if (imem_ack) begin
          // A redirect seen during this fetch (or on its ack) discards the word.
          if (redirect || pend_q) begin
            {mis, pc_next} = apply_target(redirect ? redirect_target : pend_tgt_q);
            pend_d     = 1'b0;
            state_d    = REQ;
            imem_req_d = 1'b1;
          end else begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
            imem_req_d    = 1'b0;
          end
        end else if (redirect) begin
          pend_d     = 1'b1;
          pend_tgt_d = redirect_target;
        end
      end
      HOLD: begin
        if (redirect) begin
          {mis, pc_next} = apply_target(redirect_target);
          instr_valid_d  = 1'b0;
          state_d        = REQ;
          imem_req_d     = 1'b1;
        end else if (instr_ready) begin
          pc_next       = PC + SIZE'(4);
          instr_valid_d = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = REQ;
          imem_req_d    = 1'b1;
        end
      end
      default: begin
        state_d    = BOOT;
        imem_req_d = 1'b0;
      end
    endcase
    if (!RESET_N) begin
      pc_next = RESET_ADDR;
      mis     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q       <= BOOT;
      imem_req_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
      pend_q        <= 1'b0;
      pend_tgt_q    <= '0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
      pend_q        <= pend_d;
      pend_tgt_q    <= pend_tgt_d;
    end
  end

  assign PC_in       = pc_next;
  assign imem_req    = imem_req_q;
  assign imem_addr   = PC;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign misalign    = mis;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: table of per-cycle vectors plus a hand-written fetch sequence.
module tb_pc_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] PC;
  logic [31:0] PC_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        misalign;
  logic [31:0] fetch_count;

  int total = 0;
  int passed = 0;

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] XT = 32'h0000_0010;
  localparam logic        XM = 1'b1;
`else
  localparam logic [31:0] XT = 32'h0000_0100;
  localparam logic        XM = 1'b0;
`endif

  pc_fetch_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC(PC), .PC_in(PC_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .misalign(misalign),
    .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  // External PC register loaded from PC_in every cycle.
  always @(posedge CLK) PC <= PC_in;

  typedef struct {
    logic        rst_n, ack;
    logic [31:0] rdata;
    logic        rdy, redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr, e_pc_in, e_cnt;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic ack, input logic [31:0] rdata,
                     input logic rdy, input logic redir, input logic [31:0] tgt,
                     input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                     input logic [31:0] e_instr, input logic [31:0] e_pc_in,
                     input logic [31:0] e_cnt, input logic e_mis);
    vec_t v;
    v.rst_n = rst_n; v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr;
    v.e_pc_in = e_pc_in; v.e_cnt = e_cnt; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic rst_n, input logic ack, input logic [31:0] rdata,
                       input logic rdy, input logic redir, input logic [31:0] tgt);
    RESET_N = rst_n; imem_ack = ack; imem_rdata = rdata;
    instr_ready = rdy; redirect = redir; redirect_target = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge CLK);

    add(0,0,32'h0,0,0,32'h0,                1,32'h0,0,32'h0,32'h0,0,0);
    vecs[0].e_req = 1'b0;
    add(1,1,32'hDEAD,0,1,32'h200,           0,32'h0,0,32'h0,32'h0,0,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'h0,0,32'h0,32'h0,0,0);
    add(1,1,32'hA0,1,0,32'h0,               1,32'h0,0,32'h0,32'h0,0,0);
    add(1,0,32'h0,1,0,32'h0,                0,32'h0,1,32'hA0,32'h4,0,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'h4,0,32'hA0,32'h4,1,0);
    add(1,1,32'hA1,0,0,32'h0,               1,32'h4,0,32'hA0,32'h4,1,0);
    add(1,0,32'h0,1,0,32'h0,                0,32'h4,1,32'hA1,32'h8,1,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'h8,0,32'hA1,32'h8,2,0);
    add(1,1,32'hA2,0,0,32'h0,               1,32'h8,0,32'hA1,32'h8,2,0);
    add(1,0,32'h0,1,0,32'h0,                0,32'h8,1,32'hA2,32'hC,2,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'hC,0,32'hA2,32'hC,3,0);
    // Redirect during REQ, ack two cycles later: word dropped.
    add(1,0,32'h0,0,1,32'h100,              1,32'hC,0,32'hA2,32'hC,3,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'hC,0,32'hA2,32'hC,3,0);
    add(1,1,32'hBAD,0,0,32'h0,              1,32'hC,0,32'hA2,32'h100,3,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'h100,0,32'hA2,32'h100,3,0);
    add(1,1,32'hB0,0,0,32'h0,               1,32'h100,0,32'hA2,32'h100,3,0);
    for (int i = 0; i < 5; i++)
      add(1,0,32'h0,0,0,32'h0,              0,32'h100,1,32'hB0,32'h100,3,0);
    add(1,0,32'h0,1,1,32'h40,               0,32'h100,1,32'hB0,32'h40,3,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'h40,0,32'hB0,32'h40,3,0);
    // Redirect on the ack cycle itself.
    add(1,1,32'hC0,0,1,32'hFFFF_FFFC,       1,32'h40,0,32'hB0,32'hFFFF_FFFC,3,0);
    add(1,1,32'hC1,0,0,32'h0,               1,32'hFFFF_FFFC,0,32'hB0,32'hFFFF_FFFC,3,0);
    add(1,0,32'h0,1,0,32'h0,                0,32'hFFFF_FFFC,1,32'hC1,32'h0,3,0);
    // Second pending redirect overwrites the first.
    add(1,0,32'h0,0,1,32'h300,              1,32'h0,0,32'hC1,32'h0,4,0);
    add(1,0,32'h0,0,1,32'h500,              1,32'h0,0,32'hC1,32'h0,4,0);
    add(1,1,32'hD0,0,0,32'h0,               1,32'h0,0,32'hC1,32'h500,4,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'h500,0,32'hC1,32'h500,4,0);
    add(1,1,32'hD1,0,0,32'h0,               1,32'h500,0,32'hC1,32'h500,4,0);
    add(1,0,32'h0,0,1,32'h102,              0,32'h500,1,32'hD1,XT,4,XM);
    add(1,0,32'h0,0,0,32'h0,                1,XT,0,32'hD1,XT,4,0);
    // Reset mid-REQ, then a late ack in BOOT.
    add(0,0,32'h0,0,0,32'h0,                1,XT,0,32'hD1,32'h0,4,0);
    add(1,1,32'hEE,0,0,32'h0,               0,32'h0,0,32'h0,32'h0,0,0);
    add(1,0,32'h0,0,0,32'h0,                1,32'h0,0,32'h0,32'h0,0,0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].rst_n, vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
      #1;
      chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_vld});
      chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
      chk($sformatf("v%0d PC_in", i), PC_in, vecs[i].e_pc_in);
      chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_cnt);
      chk($sformatf("v%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].e_mis});
    end

    // Back-to-back fetches from reset address: 0x0, 0x4, 0x8.
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      drive(1'b1, 1'b1, 32'h1000 + k, 1'b0, 1'b0, 32'h0);
      #1;
      chk($sformatf("seq%0d imem_req", k), {31'b0, imem_req}, 32'd1);
      chk($sformatf("seq%0d imem_addr", k), imem_addr, 32'(4 * k));
      @(negedge CLK);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      #1;
      chk($sformatf("seq%0d instr_valid", k), {31'b0, instr_valid}, 32'd1);
      chk($sformatf("seq%0d instr", k), instr, 32'h1000 + k);
      chk($sformatf("seq%0d PC_in", k), PC_in, 32'(4 * k + 4));
    end
    @(negedge CLK);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("seq fetch_count", fetch_count, 32'd3);
    chk("seq next imem_addr", imem_addr, 32'hC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
